// File: rtl/regfile_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_writeback_arbiter
//
// Write-back stage that owns the single write port of the 2R/1W register
// file. Single-cycle ALU results always win the port; long-latency load
// results wait in a small in-order queue and drain whenever the ALU leaves
// the port idle. A per-register busy scoreboard tracks loads that have been
// issued but not yet written, so decode can stall on RAW/WAW hazards.
//
// Optional feature (compile-time macro):
//   RF_WB_BYPASS_EN  - when defined, a load result that arrives while the
//                      queue is empty and no ALU result is present is written
//                      directly (one cycle earlier) instead of being queued.
//                      When undefined, every load goes through the queue.
//
// Parameters:
//   DATA_WIDTH     result / write data width
//   REG_NUM_WIDTH  register number width
//   REG_FILE_SIZE  number of architectural registers (busy mask width)
//   FIFO_DEPTH     load queue entries (power of 2, at least 2)
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   aluValid      ALU result valid this cycle (never stalled)
//   aluNum        ALU destination register
//   aluData       ALU result
//   ldIssue       load issued this cycle; marks ldIssueNum busy
//   ldIssueNum    destination of the issued load
//   ldValid       load result offered
//   ldReady       load result accepted when ldValid && ldReady
//   ldNum         load result destination register
//   ldData        load result data
//   busy          bit r set: load to r issued and not yet written
//   qCount        load queue occupancy
//   wrData        register file write data (registered)
//   wrNum         register file write number (registered)
//   wrEnable      register file write enable (registered)
// ---------------------------------------------------------------------------
module regfile_writeback_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5,
  parameter int REG_FILE_SIZE = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          aluValid,
  input  logic [REG_NUM_WIDTH-1:0]      aluNum,
  input  logic [DATA_WIDTH-1:0]         aluData,
  input  logic                          ldIssue,
  input  logic [REG_NUM_WIDTH-1:0]      ldIssueNum,
  input  logic                          ldValid,
  output logic                          ldReady,
  input  logic [REG_NUM_WIDTH-1:0]      ldNum,
  input  logic [DATA_WIDTH-1:0]         ldData,
  output logic [REG_FILE_SIZE-1:0]      busy,
  output logic [$clog2(FIFO_DEPTH):0]   qCount,
  output logic [DATA_WIDTH-1:0]         wrData,
  output logic [REG_NUM_WIDTH-1:0]      wrNum,
  output logic                          wrEnable
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]         FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]         PTR_ONE    = PTR_W'(1);
  localparam logic [REG_FILE_SIZE-1:0] BUSY_ONE   = REG_FILE_SIZE'(1);

  // One queued load result: destination register plus its data.
  typedef struct packed {
    logic [REG_NUM_WIDTH-1:0] num;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  entry_t                   queue_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         head_ptr;
  logic [PTR_W-1:0]         tail_ptr;
  logic [CNT_W-1:0]         count;

  logic                     queue_empty;
  logic                     load_accept;
  logic                     load_nonzero;
  logic                     take_queue;
  logic                     take_bypass;
  logic                     do_push;
  logic                     do_pop;
  logic                     sel_valid;
  logic [REG_NUM_WIDTH-1:0] sel_num;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [REG_FILE_SIZE-1:0] clear_mask;
  logic [REG_FILE_SIZE-1:0] set_mask;
  entry_t                   head_entry;

  // ldReady depends only on the registered occupancy, so a full queue
  // refuses a new load even in the cycle it is popping; this keeps
  // aluValid/ldValid off any combinational path to ldReady.
  assign ldReady    = (count != FULL_COUNT);
  assign qCount     = count;
  assign head_entry = queue_mem[head_ptr];

  // Write port selection. The ALU always owns the port when it has a result;
  // an ALU result to r0 still occupies the port but produces no write. The
  // queue head drains only when the ALU is silent. With the bypass built in,
  // a load arriving to an empty queue on an idle port skips the queue.
  always_comb begin
    queue_empty  = (count == '0);
    load_accept  = ldValid && ldReady;
    load_nonzero = (ldNum != '0);
    take_queue   = !aluValid && !queue_empty;
`ifdef RF_WB_BYPASS_EN
    take_bypass  = !aluValid && queue_empty && load_accept;
`else
    take_bypass  = 1'b0;
`endif
    do_pop       = take_queue;
    // Loads to r0 complete the handshake but are simply dropped.
    do_push      = load_accept && load_nonzero && !take_bypass;

    sel_valid    = 1'b0;
    sel_num      = '0;
    sel_data     = '0;
    clear_mask   = '0;

    if (aluValid) begin
      sel_valid = (aluNum != '0);
      sel_num   = aluNum;
      sel_data  = aluData;
    end else if (take_queue) begin
      sel_valid  = 1'b1;
      sel_num    = head_entry.num;
      sel_data   = head_entry.data;
      clear_mask = BUSY_ONE << head_entry.num;
    end else if (take_bypass) begin
      sel_valid  = load_nonzero;
      sel_num    = ldNum;
      sel_data   = ldData;
      clear_mask = load_nonzero ? (BUSY_ONE << ldNum) : '0;
    end

    set_mask = (ldIssue && (ldIssueNum != '0)) ? (BUSY_ONE << ldIssueNum) : '0;
  end

  // Queue storage carries no reset; only the pointers and count define
  // which entries are live, so clearing those discards everything.
  always_ff @(posedge clk) begin
    if (do_push) begin
      queue_mem[tail_ptr].num  <= ldNum;
      queue_mem[tail_ptr].data <= ldData;
    end
  end

  // Queue pointers and occupancy. Pointers wrap naturally because the depth
  // is a power of two; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        tail_ptr <= tail_ptr + PTR_ONE;
      end
      if (do_pop) begin
        head_ptr <= head_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Pending-load scoreboard. A bit clears in the cycle its queued (or
  // bypassed) write is selected; a new issue to the same register in that
  // cycle must leave it set, so the set mask is applied last.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clear_mask) | set_mask;
    end
  end

  // Registered write port. Number and data only change when a write is
  // actually selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrEnable <= 1'b0;
      wrNum    <= '0;
      wrData   <= '0;
    end else begin
      wrEnable <= sel_valid;
      if (sel_valid) begin
        wrNum  <= sel_num;
        wrData <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_arbiter
//
// Self-checking bench for regfile_writeback_arbiter. A behavioural model
// (queue of pending load results, busy bit vector, expected write) is
// advanced once per clock from the same inputs the DUT sees. Directed tasks
// check the documented scenarios against literal values; a randomized task
// checks every cycle against the model. Honours RF_WB_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        aluValid;
  logic [4:0]  aluNum;
  logic [31:0] aluData;
  logic        ldIssue;
  logic [4:0]  ldIssueNum;
  logic        ldValid;
  logic        ldReady;
  logic [4:0]  ldNum;
  logic [31:0] ldData;
  logic [31:0] busy;
  logic [2:0]  qCount;
  logic [31:0] wrData;
  logic [4:0]  wrNum;
  logic        wrEnable;

  int checks = 0;
  int errors = 0;

  regfile_writeback_arbiter #(
    .DATA_WIDTH(32), .REG_NUM_WIDTH(5), .REG_FILE_SIZE(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluNum(aluNum), .aluData(aluData),
    .ldIssue(ldIssue), .ldIssueNum(ldIssueNum),
    .ldValid(ldValid), .ldReady(ldReady), .ldNum(ldNum), .ldData(ldData),
    .busy(busy), .qCount(qCount),
    .wrData(wrData), .wrNum(wrNum), .wrEnable(wrEnable)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [4:0]  num;
    logic [31:0] data;
  } ld_t;

  ld_t         mq[$];
  logic [31:0] mbusy;
  logic        exp_en;
  logic [4:0]  exp_num;
  logic [31:0] exp_data;

  function automatic void model_reset();
    mq.delete();
    mbusy    = '0;
    exp_en   = 1'b0;
    exp_num  = '0;
    exp_data = '0;
  endfunction

  // One clock of the write-back rules: ALU first, else oldest queued load,
  // else (bypass build) a fresh load to an empty queue; issues set busy last.
  function automatic void model_step();
    ld_t         e;
    logic        accepted;
    logic        bypassed;
    logic [31:0] nb;
    accepted = ldValid && (mq.size() < DEPTH);
    bypassed = 1'b0;
    nb       = mbusy;
    if (aluValid) begin
      exp_en = (aluNum != 5'd0);
      if (aluNum != 5'd0) begin
        exp_num  = aluNum;
        exp_data = aluData;
      end
    end else if (mq.size() > 0) begin
      e        = mq.pop_front();
      exp_en   = 1'b1;
      exp_num  = e.num;
      exp_data = e.data;
      nb[e.num] = 1'b0;
    end else begin
      exp_en = 1'b0;
`ifdef RF_WB_BYPASS_EN
      if (accepted) begin
        bypassed = 1'b1;
        if (ldNum != 5'd0) begin
          exp_en   = 1'b1;
          exp_num  = ldNum;
          exp_data = ldData;
          nb[ldNum] = 1'b0;
        end
      end
`endif
    end
    if (accepted && !bypassed && ldNum != 5'd0) begin
      e.num  = ldNum;
      e.data = ldData;
      mq.push_back(e);
    end
    if (ldIssue && ldIssueNum != 5'd0) nb[ldIssueNum] = 1'b1;
    mbusy = nb;
  endfunction

  // Advance model and DUT by one clock; outputs are sampled 1 time unit later.
  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluValid   = 1'b0; aluNum = '0; aluData = '0;
    ldIssue    = 1'b0; ldIssueNum = '0;
    ldValid    = 1'b0; ldNum = '0; ldData = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (wrEnable !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrEnable: got %0b expected 0", wrEnable); end
    checks++; if (wrNum !== 5'd0) begin errors++; $display("[TB] FAIL reset_wrNum: got %0d expected 0", wrNum); end
    checks++; if (wrData !== 32'd0) begin errors++; $display("[TB] FAIL reset_wrData: got %h expected 0", wrData); end
    checks++; if (busy !== 32'd0) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 0", busy); end
    checks++; if (qCount !== 3'd0) begin errors++; $display("[TB] FAIL reset_qCount: got %0d expected 0", qCount); end
    checks++; if (ldReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ldReady: got %0b expected 1", ldReady); end
    rst = 1'b0;
  endtask

  task automatic test_alu_only();
    idle_inputs();
    aluValid = 1'b1; aluNum = 5'd5; aluData = 32'hDEADBEEF;
    tick();
    checks++; if (wrEnable !== 1'b1) begin errors++; $display("[TB] FAIL alu_wrEnable: got %0b expected 1", wrEnable); end
    checks++; if (wrNum !== 5'd5) begin errors++; $display("[TB] FAIL alu_wrNum: got %0d expected 5", wrNum); end
    checks++; if (wrData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL alu_wrData: got %h expected deadbeef", wrData); end
    aluNum = 5'd0; aluData = 32'h12345678;
    tick();
    checks++; if (wrEnable !== 1'b0) begin errors++; $display("[TB] FAIL alu_r0_wrEnable: got %0b expected 0", wrEnable); end
    idle_inputs();
    tick();
    checks++; if (wrEnable !== 1'b0) begin errors++; $display("[TB] FAIL alu_idle_wrEnable: got %0b expected 0", wrEnable); end
  endtask

  task automatic test_contention();
    idle_inputs();
    ldIssue = 1'b1; ldIssueNum = 5'd7;
    tick();
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("[TB] FAIL cont_busy_set: got %0b expected 1", busy[7]); end
    ldIssue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      aluValid = 1'b1; aluNum = 5'(10 + i); aluData = 32'(32'hA0 + i);
      ldValid  = (i == 0); ldNum = 5'd7; ldData = 32'h11;
      tick();
      checks++; if (wrEnable !== 1'b1 || wrNum !== 5'(10 + i) || wrData !== 32'(32'hA0 + i)) begin
        errors++; $display("[TB] FAIL cont_alu_write%0d: got en=%0b num=%0d data=%h expected en=1 num=%0d data=%h",
                           i, wrEnable, wrNum, wrData, 10 + i, 32'hA0 + i);
      end
      checks++; if (busy[7] !== 1'b1) begin errors++; $display("[TB] FAIL cont_busy_held%0d: got %0b expected 1", i, busy[7]); end
      checks++; if (qCount !== 3'd1) begin errors++; $display("[TB] FAIL cont_qCount%0d: got %0d expected 1", i, qCount); end
    end
    idle_inputs();
    tick();
    checks++; if (wrEnable !== 1'b1 || wrNum !== 5'd7 || wrData !== 32'h11) begin
      errors++; $display("[TB] FAIL cont_load_write: got en=%0b num=%0d data=%h expected en=1 num=7 data=11", wrEnable, wrNum, wrData);
    end
    checks++; if (busy[7] !== 1'b0) begin errors++; $display("[TB] FAIL cont_busy_clear: got %0b expected 0", busy[7]); end
    checks++; if (qCount !== 3'd0) begin errors++; $display("[TB] FAIL cont_qCount_end: got %0d expected 0", qCount); end
  endtask

  task automatic test_full();
    idle_inputs();
    for (int k = 1; k <= 5; k++) begin
      aluValid = 1'b1; aluNum = 5'd20; aluData = 32'(k);
      ldValid = 1'b1; ldNum = 5'(k); ldData = 32'(32'h100 + k);
      checks++; if (ldReady !== (k <= 4)) begin errors++; $display("[TB] FAIL full_ldReady%0d: got %0b expected %0b", k, ldReady, k <= 4); end
      tick();
      checks++; if (qCount !== 3'((k > 4) ? 4 : k)) begin errors++; $display("[TB] FAIL full_qCount%0d: got %0d expected %0d", k, qCount, (k > 4) ? 4 : k); end
    end
    // First drain cycle: queue full and popping, a new offer is still refused.
    aluValid = 1'b0; ldValid = 1'b1; ldNum = 5'd6; ldData = 32'h106;
    checks++; if (ldReady !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_ldReady: got %0b expected 0", ldReady); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      ldValid = 1'b0;
      checks++; if (wrEnable !== 1'b1 || wrNum !== 5'(k) || wrData !== 32'(32'h100 + k)) begin
        errors++; $display("[TB] FAIL full_drain%0d: got en=%0b num=%0d data=%h expected en=1 num=%0d data=%h",
                           k, wrEnable, wrNum, wrData, k, 32'h100 + k);
      end
      checks++; if (qCount !== 3'(4 - k)) begin errors++; $display("[TB] FAIL full_drain_qCount%0d: got %0d expected %0d", k, qCount, 4 - k); end
    end
    idle_inputs();
    tick();
    checks++; if (wrEnable !== 1'b0) begin errors++; $display("[TB] FAIL full_after_drain: got en=%0b expected 0", wrEnable); end
  endtask

  task automatic test_hazard();
    idle_inputs();
    ldIssue = 1'b1; ldIssueNum = 5'd9;
    tick();
    idle_inputs();
    aluValid = 1'b1; aluNum = 5'd1; aluData = 32'h0;
    ldValid = 1'b1; ldNum = 5'd9; ldData = 32'h99;
    tick();
    checks++; if (qCount !== 3'd1) begin errors++; $display("[TB] FAIL hazard_queued: got %0d expected 1", qCount); end
    idle_inputs();
    ldIssue = 1'b1; ldIssueNum = 5'd9;
    tick();
    checks++; if (wrEnable !== 1'b1 || wrNum !== 5'd9 || wrData !== 32'h99) begin
      errors++; $display("[TB] FAIL hazard_write: got en=%0b num=%0d data=%h expected en=1 num=9 data=99", wrEnable, wrNum, wrData);
    end
    checks++; if (busy[9] !== 1'b1) begin errors++; $display("[TB] FAIL hazard_set_wins: got %0b expected 1", busy[9]); end
    idle_inputs();
    tick();
    checks++; if (busy[9] !== 1'b1) begin errors++; $display("[TB] FAIL hazard_busy_held: got %0b expected 1", busy[9]); end
  endtask

  task automatic test_load_latency();
    idle_inputs();
    ldIssue = 1'b1; ldIssueNum = 5'd3;
    tick();
    idle_inputs();
    ldValid = 1'b1; ldNum = 5'd3; ldData = 32'h42;
    tick();
    idle_inputs();
`ifdef RF_WB_BYPASS_EN
    checks++; if (wrEnable !== 1'b1 || wrNum !== 5'd3 || wrData !== 32'h42) begin
      errors++; $display("[TB] FAIL lat_bypass_write: got en=%0b num=%0d data=%h expected en=1 num=3 data=42", wrEnable, wrNum, wrData);
    end
    checks++; if (busy[3] !== 1'b0 || qCount !== 3'd0) begin
      errors++; $display("[TB] FAIL lat_bypass_state: got busy3=%0b q=%0d expected busy3=0 q=0", busy[3], qCount);
    end
    tick();
    checks++; if (wrEnable !== 1'b0) begin errors++; $display("[TB] FAIL lat_bypass_after: got en=%0b expected 0", wrEnable); end
`else
    checks++; if (wrEnable !== 1'b0 || qCount !== 3'd1 || busy[3] !== 1'b1) begin
      errors++; $display("[TB] FAIL lat_queued: got en=%0b q=%0d busy3=%0b expected en=0 q=1 busy3=1", wrEnable, qCount, busy[3]);
    end
    tick();
    checks++; if (wrEnable !== 1'b1 || wrNum !== 5'd3 || wrData !== 32'h42) begin
      errors++; $display("[TB] FAIL lat_write: got en=%0b num=%0d data=%h expected en=1 num=3 data=42", wrEnable, wrNum, wrData);
    end
    checks++; if (busy[3] !== 1'b0) begin errors++; $display("[TB] FAIL lat_busy_clear: got %0b expected 0", busy[3]); end
`endif
    // A load result to r0 is accepted but never written or queued.
    ldValid = 1'b1; ldNum = 5'd0; ldData = 32'h77;
    checks++; if (ldReady !== 1'b1) begin errors++; $display("[TB] FAIL r0_ldReady: got %0b expected 1", ldReady); end
    tick();
    idle_inputs();
    checks++; if (qCount !== 3'd0 || wrEnable !== 1'b0) begin
      errors++; $display("[TB] FAIL r0_dropped: got q=%0d en=%0b expected q=0 en=0", qCount, wrEnable);
    end
    tick();
    checks++; if (wrEnable !== 1'b0) begin errors++; $display("[TB] FAIL r0_no_write: got en=%0b expected 0", wrEnable); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      aluValid   = ($urandom_range(0, 99) < 55);
      aluNum     = 5'($urandom_range(1, 31));
      aluData    = $urandom;
      ldIssue    = ($urandom_range(0, 99) < 30);
      ldIssueNum = 5'($urandom_range(0, 31));
      ldValid    = ($urandom_range(0, 99) < 50);
      ldNum      = 5'($urandom_range(0, 31));
      ldData     = $urandom;
      checks++; if (ldReady !== (mq.size() < DEPTH)) begin
        errors++; $display("[TB] FAIL rand_ldReady c%0d: got %0b expected %0b", c, ldReady, mq.size() < DEPTH);
      end
      tick();
      checks++; if (wrEnable !== exp_en) begin errors++; $display("[TB] FAIL rand_wrEnable c%0d: got %0b expected %0b", c, wrEnable, exp_en); end
      if (exp_en) begin
        checks++; if (wrNum !== exp_num || wrData !== exp_data) begin
          errors++; $display("[TB] FAIL rand_write c%0d: got num=%0d data=%h expected num=%0d data=%h", c, wrNum, wrData, exp_num, exp_data);
        end
      end
      checks++; if (busy !== mbusy) begin errors++; $display("[TB] FAIL rand_busy c%0d: got %h expected %h", c, busy, mbusy); end
      checks++; if (qCount !== 3'(mq.size())) begin errors++; $display("[TB] FAIL rand_qCount c%0d: got %0d expected %0d", c, qCount, mq.size()); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_traffic();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      aluValid = 1'b1; aluNum = 5'd2; aluData = 32'(i);
      ldIssue = 1'b1; ldIssueNum = 5'(14 + i);
      ldValid = 1'b1; ldNum = 5'(11 + i); ldData = 32'(32'h500 + i);
      tick();
    end
    checks++; if (qCount === 3'd0 || busy === 32'd0) begin
      errors++; $display("[TB] FAIL midrst_preload: got q=%0d busy=%h expected nonzero", qCount, busy);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (wrEnable !== 1'b0 || busy !== 32'd0 || qCount !== 3'd0 || ldReady !== 1'b1) begin
        errors++; $display("[TB] FAIL midrst_cycle%0d: got en=%0b busy=%h q=%0d rdy=%0b expected en=0 busy=0 q=0 rdy=1",
                           i, wrEnable, busy, qCount, ldReady);
      end
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (wrEnable !== 1'b0 || qCount !== 3'd0) begin
        errors++; $display("[TB] FAIL midrst_dropped%0d: got en=%0b q=%0d expected en=0 q=0", i, wrEnable, qCount);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_alu_only();
    test_contention();
    test_full();
    test_hazard();
    test_load_latency();
    test_random();
    test_reset_mid_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
